// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding
// and default sizing constants.
package arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE          = 2'd0,
    S_WAIT_MEM_HIGH = 2'd1,
    S_WAIT_RQ_LOW   = 2'd2,
    S_WAIT_MEM_LOW  = 2'd3
  } arb_state_t;

  localparam int N_CORES_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Shared memory bus as seen by the arbiter: per-core requests, memory Ready,
// and the arbiter's grant/status outputs.
interface bus_arbiter_rr_if #(
  parameter int N_CORES = 4,
  parameter int ID_W    = 2
);

  logic [N_CORES-1:0] Bus_RQ;
  logic               Bus_Mem_Ready;
  logic [N_CORES-1:0] Bus_GRANT;
  logic [ID_W-1:0]    Grant_Id;
  logic               Bus_Busy;
  logic               Timeout_Err;

  // Arbiter side
  modport master (
    input  Bus_RQ,
    input  Bus_Mem_Ready,
    output Bus_GRANT,
    output Grant_Id,
    output Bus_Busy,
    output Timeout_Err
  );

  // Requester / memory side
  modport slave (
    output Bus_RQ,
    output Bus_Mem_Ready,
    input  Bus_GRANT,
    input  Grant_Id,
    input  Bus_Busy,
    input  Timeout_Err
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate the request vector so ptr sits at bit 0, take the
// lowest set bit, then map the offset back to a core index.
module rr_priority_pick #(
  parameter int N_CORES = 4,
  parameter int ID_W    = 2
) (
  input  logic [N_CORES-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx,
  output logic [N_CORES-1:0] onehot
);

  localparam logic [ID_W:0] N_EXT = (ID_W + 1)'(N_CORES);

  logic [N_CORES-1:0] rotated;
  logic [ID_W-1:0]    offset;

  // a + b modulo N_CORES; both operands are below N_CORES so one subtract suffices
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a,
                                               input logic [ID_W-1:0] b);
    logic [ID_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= N_EXT) begin
      sum = sum - N_EXT;
    end
    return sum[ID_W-1:0];
  endfunction

  // Rotate requests so the core at ptr lands on bit 0
  always_comb begin
    rotated = {N_CORES{1'b0}};
    for (int i = 0; i < N_CORES; i++) begin
      rotated[i] = req[wrap_add(ID_W'(i), ptr)];
    end
  end

  // Lowest set bit of the rotated vector; descending scan lets the lowest win
  always_comb begin
    valid  = 1'b0;
    offset = {ID_W{1'b0}};
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        valid  = 1'b1;
        offset = ID_W'(i);
      end else begin
        valid  = valid;
        offset = offset;
      end
    end
  end

  // Map the winning offset back to an absolute index and one-hot vector
  always_comb begin
    idx    = wrap_add(offset, ptr);
    onehot = {N_CORES{1'b0}};
    if (valid) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = {N_CORES{1'b0}};
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for one shared memory bus. Holds a registered one-hot
// grant across the Ready-high / RQ-low / Ready-low handshake, with a watchdog.
module bus_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEFAULT,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  bus_arbiter_rr_if.master bus
);

  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_CORES - 1);
  localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(32'd1);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WD_ONE   = CNT_W'(32'd1);

  arb_state_t         state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   wdog;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_idx;
  logic [N_CORES-1:0] pick_onehot;
  logic               grantee_rq;

  rr_priority_pick #(
    .N_CORES (N_CORES),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (bus.Bus_RQ),
    .ptr    (ptr),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign grantee_rq = bus.Bus_RQ[bus.Grant_Id];

  // Arbitration FSM, rr pointer, watchdog and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      ptr             <= {ID_W{1'b0}};
      wdog            <= {CNT_W{1'b0}};
      bus.Bus_GRANT   <= {N_CORES{1'b0}};
      bus.Grant_Id    <= {ID_W{1'b0}};
      bus.Bus_Busy    <= 1'b0;
      bus.Timeout_Err <= 1'b0;
    end else begin
      bus.Timeout_Err <= 1'b0;
      case (state)
        S_IDLE: begin
          // A high Ready here is stale from the previous owner: hold off
          if (pick_valid && !bus.Bus_Mem_Ready) begin
            bus.Bus_GRANT <= pick_onehot;
            bus.Grant_Id  <= pick_idx;
            ptr           <= (pick_idx == LAST_ID) ? {ID_W{1'b0}} : pick_idx + ID_ONE;
            wdog          <= {CNT_W{1'b0}};
            bus.Bus_Busy  <= 1'b1;
            state         <= S_WAIT_MEM_HIGH;
          end
        end
        S_WAIT_MEM_HIGH: begin
          if (bus.Bus_Mem_Ready) begin
            state <= S_WAIT_RQ_LOW;
          end else if (!grantee_rq) begin
            bus.Bus_GRANT <= {N_CORES{1'b0}};
            state         <= S_WAIT_MEM_LOW;
          end else if (wdog == WD_LIMIT) begin
            bus.Bus_GRANT   <= {N_CORES{1'b0}};
            bus.Timeout_Err <= 1'b1;
            state           <= S_WAIT_MEM_LOW;
          end else begin
            wdog <= wdog + WD_ONE;
          end
        end
        S_WAIT_RQ_LOW: begin
          if (!grantee_rq) begin
            bus.Bus_GRANT <= {N_CORES{1'b0}};
            state         <= S_WAIT_MEM_LOW;
          end
        end
        S_WAIT_MEM_LOW: begin
          if (!bus.Bus_Mem_Ready) begin
            bus.Bus_Busy <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          bus.Bus_GRANT <= {N_CORES{1'b0}};
          bus.Bus_Busy  <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule
